// File: rtl/qam16_symbol_upsampler.sv
// 16-QAM transmit front stage: symbol FIFO, Gray mapping to signed I/Q levels,
// zero-stuffing by OSR at a CE_DIV-clock sample rate, and a zero flush so the pulse-shaping filters drain.
module qam16_symbol_upsampler #(
   parameter int WIDTH_DATA = 16,
   parameter int OSR        = 4,
   parameter int CE_DIV     = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int FLUSH_LEN  = 16,
   parameter int LEVEL_1    = 2048
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [3:0]            sym_in,
   input  logic                  sym_valid,
   output logic                  sym_ready,
   output logic [WIDTH_DATA-1:0] i_out,
   output logic [WIDTH_DATA-1:0] q_out,
   output logic                  ce_shift,
   output logic                  start,
   output logic                  busy
);

   // Handshake: a symbol transfers on any rising edge where sym_valid and sym_ready are both high.
   localparam int DIV_W = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
   localparam int PH_W  = $clog2(OSR);
   localparam int FL_W  = $clog2(FLUSH_LEN + 1);
   localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW    = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t            state, state_n;
   logic [DIV_W-1:0]  div_cnt, div_n;
   logic [PH_W-1:0]   phase, phase_n;
   logic [FL_W-1:0]   flush_cnt, flush_n;
   logic [CW-1:0]     count, count_n;
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [3:0]        mem [FIFO_DEPTH];
   logic [3:0]        head;
   logic [WIDTH_DATA-1:0] i_n, q_n;
   logic              ce_n, start_n, pop, push, full, init_done;

   function automatic logic [WIDTH_DATA-1:0] map_level(input logic [1:0] bits);
      int v;
      case (bits)
         2'b00:   v = -3 * LEVEL_1;
         2'b01:   v = -LEVEL_1;
         2'b11:   v = LEVEL_1;
         default: v = 3 * LEVEL_1;
      endcase
      return WIDTH_DATA'(v);
   endfunction

   // init_done keeps sym_ready low until the first edge after reset releases.
   assign full      = (count == CW'(FIFO_DEPTH));
   assign sym_ready = init_done & ~full;
   assign push      = sym_valid & sym_ready;
   assign head      = mem[rd_ptr];
   assign busy      = (state != IDLE);

   always_comb begin
      state_n = state;
      div_n   = div_cnt;
      phase_n = phase;
      flush_n = flush_cnt;
      ce_n    = 1'b0;
      i_n     = i_out;
      q_n     = q_out;
      start_n = start;
      pop     = 1'b0;
      case (state)
         IDLE: begin
            if (count != '0 && en) begin
               state_n = RUN;
               div_n   = '0;
               phase_n = '0;
               start_n = 1'b1;
            end
         end
         RUN, FLUSH: begin
            if (en) begin
               if (div_cnt == DIV_W'(CE_DIV - 1)) begin
                  div_n   = '0;
                  ce_n    = 1'b1;
                  phase_n = (phase == PH_W'(OSR - 1)) ? '0 : phase + 1'b1;
                  i_n     = '0;
                  q_n     = '0;
                  if (phase == '0 && count != '0) begin
                     pop     = 1'b1;
                     i_n     = map_level(head[3:2]);
                     q_n     = map_level(head[1:0]);
                     state_n = RUN;
                  end else if (state == RUN) begin
                     if (phase == '0) begin
                        flush_n = FL_W'(1);
                        state_n = FLUSH;
                     end
                  end else begin
                     // Last flush sample still strobes; the filters see it as a zero.
                     flush_n = flush_cnt + 1'b1;
                     if (flush_cnt == FL_W'(FLUSH_LEN - 1)) begin
                        state_n = IDLE;
                        start_n = 1'b0;
                     end
                  end
               end else begin
                  div_n = div_cnt + 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      count_n = count;
      case ({push, pop})
         2'b10:   count_n = count + 1'b1;
         2'b01:   count_n = count - 1'b1;
         default: count_n = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         div_cnt   <= '0;
         phase     <= '0;
         flush_cnt <= '0;
         count     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         i_out     <= '0;
         q_out     <= '0;
         ce_shift  <= 1'b0;
         start     <= 1'b0;
         init_done <= 1'b0;
      end else begin
         state     <= state_n;
         div_cnt   <= div_n;
         phase     <= phase_n;
         flush_cnt <= flush_n;
         count     <= count_n;
         i_out     <= i_n;
         q_out     <= q_n;
         ce_shift  <= ce_n;
         start     <= start_n;
         init_done <= 1'b1;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= sym_in;
   end

endmodule

// File: tb/tb_qam16_symbol_upsampler.sv
// Directed bench for qam16_symbol_upsampler: reset, mapping, streaming, flush,
// enable freeze and mid-run reset, each checked against hand-computed samples.
module tb_qam16_symbol_upsampler;

   logic        clk, rst, en, sym_valid, sym_ready, ce_shift, start, busy;
   logic [3:0]  sym_in;
   logic [15:0] i_out, q_out;
   int          n_checks = 0;
   int          n_fails  = 0;
   int unsigned cyc = 0;
   bit          saw_block;
   // Level per Gray pair, indexed by the 2-bit code: 00,01,10,11.
   logic [15:0] lvl [4] = '{16'hE800, 16'hF800, 16'h1800, 16'h0800};

   qam16_symbol_upsampler dut (
      .clk(clk), .rst(rst), .en(en), .sym_in(sym_in), .sym_valid(sym_valid),
      .sym_ready(sym_ready), .i_out(i_out), .q_out(q_out), .ce_shift(ce_shift),
      .start(start), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Hold the symbol until an edge where sym_ready was high.
   task automatic push_sym(input logic [3:0] code);
      bit acc;
      int n;
      sym_in    = code;
      sym_valid = 1'b1;
      acc       = 1'b0;
      for (n = 0; n < 200 && !acc; n++) begin
         acc = sym_ready;
         if (!acc) saw_block = 1'b1;
         step();
      end
      n_checks++;
      if (!acc) begin
         n_fails++;
         $display("FAIL push_timeout: symbol %b never accepted", code);
      end
   endtask

   task automatic wait_tick(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 40; n++) begin
         step();
         if (ce_shift === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int n = 0; n < 300; n++) begin
         if (busy === 1'b0) begin
            done = 1'b1;
            break;
         end
         step();
      end
      n_checks++;
      if (!done) begin
         n_fails++;
         $display("FAIL idle_timeout: busy=%b expected 0", busy);
      end
      repeat (2) step();
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; sym_valid = 1'b0; sym_in = 4'h0;
      repeat (3) step();
      n_checks++;
      if ({i_out, q_out} !== 32'h0) begin
         n_fails++; $display("FAIL reset_iq: got %h/%h expected 0/0", i_out, q_out);
      end
      n_checks++;
      if ({ce_shift, start, busy, sym_ready} !== 4'b0000) begin
         n_fails++;
         $display("FAIL reset_ctrl: ce/start/busy/ready got %b expected 0000", {ce_shift, start, busy, sym_ready});
      end
      rst = 1'b0;
      n_checks++;
      if (sym_ready !== 1'b0) begin
         n_fails++; $display("FAIL reset_ready_early: got %b expected 0", sym_ready);
      end
      step();
      n_checks++;
      if (sym_ready !== 1'b1) begin
         n_fails++; $display("FAIL reset_ready_rise: got %b expected 1", sym_ready);
      end
   endtask

   task automatic test_mapping();
      sym_in = 4'b1001; sym_valid = 1'b1;
      step();
      sym_valid = 1'b0;
      n_checks++;
      if ({ce_shift, busy} !== 2'b00) begin
         n_fails++; $display("FAIL map_e0: ce/busy got %b expected 00", {ce_shift, busy});
      end
      step();
      n_checks++;
      if ({ce_shift, busy, start} !== 3'b011) begin
         n_fails++; $display("FAIL map_e1: ce/busy/start got %b expected 011", {ce_shift, busy, start});
      end
      step();
      n_checks++;
      if (ce_shift !== 1'b0) begin
         n_fails++; $display("FAIL map_e2: ce got %b expected 0", ce_shift);
      end
      step();
      n_checks++;
      if (ce_shift !== 1'b1 || i_out !== 16'h1800 || q_out !== 16'hF800) begin
         n_fails++; $display("FAIL map_first: ce=%b i=%h q=%h expected 1 1800 F800", ce_shift, i_out, q_out);
      end
      for (int k = 0; k < 3; k++) begin
         step();
         n_checks++;
         if (ce_shift !== 1'b0) begin
            n_fails++; $display("FAIL map_gap%0d: ce got %b expected 0", k, ce_shift);
         end
         step();
         n_checks++;
         if (ce_shift !== 1'b1 || {i_out, q_out} !== 32'h0) begin
            n_fails++; $display("FAIL map_stuff%0d: ce=%b i=%h q=%h expected 1 0 0", k, ce_shift, i_out, q_out);
         end
      end
      wait_idle();
   endtask

   task automatic test_all_codes();
      fork
         begin
            for (int c = 0; c < 16; c++) push_sym(c[3:0]);
            sym_valid = 1'b0;
         end
         begin
            bit ok;
            logic [3:0] cc;
            for (int t = 0; t < 64; t++) begin
               wait_tick(ok);
               cc = t[5:2];
               n_checks++;
               if (!ok) begin
                  n_fails++; $display("FAIL codes_tick%0d: no ce_shift within bound", t);
               end else if (t % 4 == 0) begin
                  if (i_out !== lvl[cc[3:2]] || q_out !== lvl[cc[1:0]]) begin
                     n_fails++;
                     $display("FAIL codes_sym%0d: got %h/%h expected %h/%h", cc, i_out, q_out, lvl[cc[3:2]], lvl[cc[1:0]]);
                  end
               end else if ({i_out, q_out} !== 32'h0) begin
                  n_fails++; $display("FAIL codes_zero%0d: got %h/%h expected 0/0", t, i_out, q_out);
               end
            end
         end
      join
      wait_idle();
   endtask

   task automatic test_back_to_back();
      logic [3:0]  codes [10] = '{4'b0000, 4'b0101, 4'b1010, 4'b1111, 4'b0010,
                                  4'b1000, 4'b0111, 4'b1101, 4'b0100, 4'b1011};
      logic [15:0] exp_i [10] = '{16'hE800, 16'hF800, 16'h1800, 16'h0800, 16'hE800,
                                  16'h1800, 16'hF800, 16'h0800, 16'hF800, 16'h1800};
      logic [15:0] exp_q [10] = '{16'hE800, 16'hF800, 16'h1800, 16'h0800, 16'h1800,
                                  16'hE800, 16'h0800, 16'hF800, 16'hE800, 16'h0800};
      saw_block = 1'b0;
      fork
         begin
            for (int k = 0; k < 10; k++) push_sym(codes[k]);
            sym_valid = 1'b0;
         end
         begin
            bit ok;
            int unsigned prev;
            prev = 0;
            for (int t = 0; t < 40; t++) begin
               wait_tick(ok);
               n_checks++;
               if (!ok) begin
                  n_fails++; $display("FAIL b2b_tick%0d: no ce_shift within bound", t);
               end else if (t % 4 == 0) begin
                  if (i_out !== exp_i[t/4] || q_out !== exp_q[t/4]) begin
                     n_fails++;
                     $display("FAIL b2b_sym%0d: got %h/%h expected %h/%h", t/4, i_out, q_out, exp_i[t/4], exp_q[t/4]);
                  end
               end else if ({i_out, q_out} !== 32'h0) begin
                  n_fails++; $display("FAIL b2b_zero%0d: got %h/%h expected 0/0", t, i_out, q_out);
               end
               if (t > 0) begin
                  n_checks++;
                  if (cyc - prev != 2) begin
                     n_fails++; $display("FAIL b2b_spacing%0d: got %0d clks expected 2", t, cyc - prev);
                  end
               end
               prev = cyc;
            end
         end
      join
      n_checks++;
      if (saw_block !== 1'b1) begin
         n_fails++; $display("FAIL b2b_full: sym_ready never dropped, got %b expected 1", saw_block);
      end
      wait_idle();
   endtask

   // Counts zero samples from the tick after a symbol until busy drops.
   task automatic count_tail(input string tag);
      bit ok;
      int zeros;
      zeros = 0;
      for (int n = 0; n < 40; n++) begin
         wait_tick(ok);
         if (!ok) break;
         zeros++;
         if ({i_out, q_out} !== 32'h0) begin
            n_checks++; n_fails++;
            $display("FAIL %s_zero: got %h/%h expected 0/0", tag, i_out, q_out);
         end
         if (busy === 1'b0) break;
      end
      n_checks++;
      if (zeros != 19 || start !== 1'b0 || busy !== 1'b0) begin
         n_fails++;
         $display("FAIL %s_len: zeros=%0d start=%b busy=%b expected 19 0 0", tag, zeros, start, busy);
      end
   endtask

   task automatic test_flush();
      bit ok, seen;
      push_sym(4'b1111);
      sym_valid = 1'b0;
      wait_tick(ok);
      n_checks++;
      if (!ok || i_out !== 16'h0800 || q_out !== 16'h0800) begin
         n_fails++; $display("FAIL flush_sym: ok=%b got %h/%h expected 0800/0800", ok, i_out, q_out);
      end
      count_tail("flush");
      seen = 1'b0;
      repeat (20) begin
         step();
         if (ce_shift !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      end
      n_checks++;
      if (seen) begin
         n_fails++; $display("FAIL flush_quiet: activity after idle got 1 expected 0");
      end
      push_sym(4'b1010);
      sym_valid = 1'b0;
      wait_tick(ok);
      n_checks++;
      if (!ok || i_out !== 16'h1800 || q_out !== 16'h1800) begin
         n_fails++; $display("FAIL midflush_a: ok=%b got %h/%h expected 1800/1800", ok, i_out, q_out);
      end
      repeat (6) wait_tick(ok);
      push_sym(4'b0001);
      sym_valid = 1'b0;
      wait_tick(ok);
      n_checks++;
      if (!ok || {i_out, q_out} !== 32'h0) begin
         n_fails++; $display("FAIL midflush_t7: ok=%b got %h/%h expected 0/0", ok, i_out, q_out);
      end
      wait_tick(ok);
      n_checks++;
      if (!ok || i_out !== 16'hE800 || q_out !== 16'hF800 || busy !== 1'b1 || start !== 1'b1) begin
         n_fails++;
         $display("FAIL midflush_b: ok=%b got %h/%h busy=%b start=%b expected E800/F800 1 1", ok, i_out, q_out, busy, start);
      end
      count_tail("midflush");
      repeat (2) step();
   endtask

   task automatic test_en_freeze();
      logic [3:0]  s [6] = '{4'b0110, 4'b1100, 4'b0001, 4'b1011, 4'b0111, 4'b1110};
      logic [15:0] ei [6] = '{16'hF800, 16'h0800, 16'hE800, 16'h1800, 16'hF800, 16'h0800};
      logic [15:0] eq [6] = '{16'h1800, 16'hE800, 16'hF800, 16'h0800, 16'h0800, 16'h1800};
      int unsigned prev;
      bit quiet;
      for (int k = 0; k < 4; k++) push_sym(s[k]);
      sym_valid = 1'b0;
      n_checks++;
      if (ce_shift !== 1'b1 || i_out !== ei[0] || q_out !== eq[0]) begin
         n_fails++; $display("FAIL en_first: ce=%b got %h/%h expected 1 %h/%h", ce_shift, i_out, q_out, ei[0], eq[0]);
      end
      prev = cyc;
      en = 1'b0; sym_in = s[4]; sym_valid = 1'b1;
      step();
      quiet = (ce_shift === 1'b0);
      sym_in = s[5];
      n_checks++;
      if (sym_ready !== 1'b0) begin
         n_fails++; $display("FAIL en_fifo_full: sym_ready got %b expected 0", sym_ready);
      end
      repeat (4) begin
         step();
         if (ce_shift !== 1'b0) quiet = 1'b0;
      end
      n_checks++;
      if (!quiet) begin
         n_fails++; $display("FAIL en_frozen: ce_shift seen while en=0, got 1 expected 0");
      end
      en = 1'b1;
      fork
         begin
            push_sym(s[5]);
            sym_valid = 1'b0;
         end
         begin
            bit ok;
            for (int t = 0; t < 20; t++) begin
               wait_tick(ok);
               n_checks++;
               if (!ok || cyc - prev != ((t == 0) ? 7 : 2)) begin
                  n_fails++;
                  $display("FAIL en_cadence%0d: ok=%b gap=%0d expected %0d", t, ok, cyc - prev, (t == 0) ? 7 : 2);
               end
               prev = cyc;
               n_checks++;
               if (t % 4 == 3) begin
                  if (i_out !== ei[1 + t/4] || q_out !== eq[1 + t/4]) begin
                     n_fails++;
                     $display("FAIL en_sym%0d: got %h/%h expected %h/%h", 1 + t/4, i_out, q_out, ei[1 + t/4], eq[1 + t/4]);
                  end
               end else if ({i_out, q_out} !== 32'h0) begin
                  n_fails++; $display("FAIL en_zero%0d: got %h/%h expected 0/0", t, i_out, q_out);
               end
            end
         end
      join
      wait_idle();
   endtask

   task automatic test_reset_mid_run();
      bit quiet;
      for (int k = 0; k < 4; k++) push_sym(4'b1001);
      sym_valid = 1'b0;
      n_checks++;
      if (busy !== 1'b1) begin
         n_fails++; $display("FAIL rstrun_busy: got %b expected 1", busy);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_checks++;
      if ({busy, start, ce_shift, sym_ready} !== 4'b0000 || {i_out, q_out} !== 32'h0) begin
         n_fails++;
         $display("FAIL rstrun_clear: busy/start/ce/ready=%b iq=%h/%h expected 0000 0/0", {busy, start, ce_shift, sym_ready}, i_out, q_out);
      end
      step();
      n_checks++;
      if (sym_ready !== 1'b1) begin
         n_fails++; $display("FAIL rstrun_ready: got %b expected 1", sym_ready);
      end
      quiet = 1'b1;
      repeat (20) begin
         step();
         if (ce_shift !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
      end
      n_checks++;
      if (!quiet) begin
         n_fails++; $display("FAIL rstrun_empty: FIFO not emptied, activity got 1 expected 0");
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; sym_valid = 1'b0; sym_in = 4'h0; saw_block = 1'b0;
      test_reset();
      test_mapping();
      test_all_codes();
      test_back_to_back();
      test_flush();
      test_en_freeze();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
